weight_flip_applier: RTL and testbench

- Downstream of the stochastic-gradient masking stage. Consumes the sparse W_SIZE-bit flip vector and applies it to the binary weight store held in a single-port BRAM, one chunk at a time, using read-modify-write (new = old XOR flip).
- Chunks with no flip bits are skipped, so BRAM traffic scales with update sparsity.
- Reports completion and the number of weights flipped.

---
 rtl/bitnet_pkg.sv | 6 +
 rtl/weight_flip_applier_popcount_chunk.sv | 13 +
 rtl/weight_flip_applier.sv | 84 ++++++++
 tb/tb_weight_flip_applier.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bitnet_pkg.sv
// bitnet_pkg: shared BitNet training constants and the flip-applier state encoding
package bitnet_pkg;
  localparam int W_SIZE_DEF = 3072;
  localparam int CHUNK_WIDTH_DEF = 64;
  typedef enum logic [2:0] {IDLE, SCAN, WAIT, WRITE, DONE} flip_state_t;
endpackage

// File: rtl/weight_flip_applier_popcount_chunk.sv
// popcount_chunk: combinational population count of one chunk (bits in, count out)
module popcount_chunk #(
  parameter int CHUNK_WIDTH = 64,
  parameter int OW = $clog2(CHUNK_WIDTH + 1)
) (
  input  logic [CHUNK_WIDTH-1:0] bits,
  output logic [OW-1:0]          count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) count = count + OW'(bits[i]);
  end
endmodule

// File: rtl/weight_flip_applier.sv
// weight_flip_applier: XORs a sparse flip mask into an external weight BRAM chunk by chunk (read-modify-write, zero chunks skipped), then pulses done_out with the flip count
module weight_flip_applier
  import bitnet_pkg::*;
#(
  parameter int W_SIZE       = W_SIZE_DEF,
  parameter int CHUNK_WIDTH  = CHUNK_WIDTH_DEF,
  parameter int READ_LATENCY = 2,
  localparam int N_CHUNKS = W_SIZE / CHUNK_WIDTH,
  localparam int AW       = $clog2(N_CHUNKS),
  localparam int CW_CNT   = $clog2(W_SIZE + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [W_SIZE-1:0]      flip_weight_in,
  input  logic                   flip_valid_in,
  output logic                   ready_out,
  output logic [AW-1:0]          bram_addr_out,
  output logic                   bram_we_out,
  output logic [CHUNK_WIDTH-1:0] bram_din_out,
  input  logic [CHUNK_WIDTH-1:0] bram_dout_in,
  output logic                   done_out,
  output logic [CW_CNT-1:0]      flips_applied_out
);
  localparam int PW = $clog2(CHUNK_WIDTH + 1);
  localparam int WW = READ_LATENCY > 2 ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
  localparam logic [AW-1:0] K_LAST = AW'(N_CHUNKS - 1);
  flip_state_t state;
  logic [W_SIZE-1:0] flip_q;
  logic [AW-1:0] k;
  logic [WW-1:0] wcnt;
  logic [CW_CNT-1:0] cnt, flips_q;
  logic [CHUNK_WIDTH-1:0] chunk;
  logic [PW-1:0] pc;
  assign chunk = flip_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
  popcount_chunk #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_pc (.bits(chunk), .count(pc));
  assign ready_out = state == IDLE;
  assign bram_addr_out = k;
  assign bram_we_out = state == WRITE;
  assign bram_din_out = bram_we_out ? bram_dout_in ^ chunk : '0;
  assign done_out = state == DONE;
  assign flips_applied_out = done_out ? cnt : flips_q;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      flip_q <= '0;
      k <= '0;
      wcnt <= '0;
      cnt <= '0;
      flips_q <= '0;
    end else begin
      case (state)
        IDLE: if (flip_valid_in) begin
          flip_q <= flip_weight_in;
          k <= '0;
          cnt <= '0;
          state <= SCAN;
        end
        SCAN: if (chunk == '0) begin
          if (k == K_LAST) state <= DONE;
          else k <= k + 1'b1;
        end else begin
          wcnt <= '0;
          state <= READ_LATENCY == 1 ? WRITE : WAIT;
        end
        WAIT: if (wcnt == W_LAST) state <= WRITE;
        else wcnt <= wcnt + 1'b1;
        WRITE: begin
          cnt <= cnt + CW_CNT'(pc);
          if (k == K_LAST) state <= DONE;
          else begin
            k <= k + 1'b1;
            state <= SCAN;
          end
        end
        DONE: begin
          flips_q <= cnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_flip_applier.sv
// tb_weight_flip_applier: directed self-checking bench with a 2-cycle-latency BRAM model
module tb_weight_flip_applier;
  localparam int W = 3072, CW = 64, NC = 48;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [W-1:0] flip_weight_in = '0;
  logic flip_valid_in = 1'b0;
  logic ready_out, bram_we_out, done_out;
  logic [5:0] bram_addr_out;
  logic [CW-1:0] bram_din_out, bram_dout_in;
  logic [11:0] flips_applied_out;
  logic [CW-1:0] mem [NC];
  logic [5:0] a1;
  logic load = 1'b0;
  int seed = 0;
  int nwr = 0, base = 0, checks = 0, errors = 0, cyc = 0, mism = 0;
  logic f1_ready;
  logic [11:0] f1_flips;
  logic [W-1:0] v, ve;
  weight_flip_applier dut (
    .clk_in(clk_in), .rst_in(rst_in), .flip_weight_in(flip_weight_in),
    .flip_valid_in(flip_valid_in), .ready_out(ready_out), .bram_addr_out(bram_addr_out),
    .bram_we_out(bram_we_out), .bram_din_out(bram_din_out), .bram_dout_in(bram_dout_in),
    .done_out(done_out), .flips_applied_out(flips_applied_out)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [CW-1:0] pat(int s, int i);
    return s == 0 ? '0 : {32'hC0DE_0000 ^ 32'(s * i), 32'(s) ^ 32'(i * 977)};
  endfunction
  always @(posedge clk_in) begin
    a1 <= bram_addr_out;
    bram_dout_in <= mem[a1];
    if (load) for (int i = 0; i < NC; i++) mem[i] <= pat(seed, i);
    else if (bram_we_out) begin
      mem[bram_addr_out] <= bram_din_out;
      nwr <= nwr + 1;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_mem(input string tag, input int s, input logic [W-1:0] prior,
                         input logic [W-1:0] fv, input int upto);
    logic [CW-1:0] e;
    mism = 0;
    for (int i = 0; i < NC; i++) begin
      e = pat(s, i) ^ prior[i*CW +: CW] ^ (i < upto ? fv[i*CW +: CW] : '0);
      if (mem[i] !== e) mism++;
    end
    chk(tag, 64'(mism), 64'd0);
  endtask
  task automatic load_mem(input int s);
    @(negedge clk_in);
    seed = s;
    load = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
  endtask
  task automatic run(input logic [W-1:0] fv);
    @(negedge clk_in);
    flip_weight_in = fv;
    flip_valid_in = 1'b1;
    @(negedge clk_in);
    flip_valid_in = 1'b0;
    cyc = 1;
    f1_ready = ready_out;
    f1_flips = flips_applied_out;
    while (done_out !== 1'b1 && cyc < 400) begin
      @(negedge clk_in);
      cyc++;
    end
  endtask
  initial begin
    load_mem(0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_we", 64'(bram_we_out), 64'd0);
    chk("rst_addr", 64'(bram_addr_out), 64'd0);
    chk("rst_din", bram_din_out, 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_flips", 64'(flips_applied_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    base = nwr;
    run('0);
    chk("zero_cycles", 64'(cyc), 64'd49);
    chk("zero_writes", 64'(nwr - base), 64'd0);
    chk("zero_flips", 64'(flips_applied_out), 64'd0);
    @(negedge clk_in);
    chk("zero_done_pulse", 64'(done_out), 64'd0);
    chk("zero_ready_after", 64'(ready_out), 64'd1);
    v = '0;
    v[0] = 1'b1;
    base = nwr;
    run(v);
    chk("bit0_cycles", 64'(cyc), 64'd51);
    chk("bit0_writes", 64'(nwr - base), 64'd1);
    chk("bit0_flips", 64'(flips_applied_out), 64'd1);
    @(negedge clk_in);
    chk_mem("bit0_mem", 0, '0, v, NC);
    chk("bit0_word0", mem[0], 64'h1);
    load_mem(7);
    v = '1;
    base = nwr;
    run(v);
    chk("ones_busy_ready", 64'(f1_ready), 64'd0);
    chk("ones_flips_held", 64'(f1_flips), 64'd1);
    chk("ones_cycles", 64'(cyc), 64'd145);
    chk("ones_writes", 64'(nwr - base), 64'd48);
    chk("ones_flips", 64'(flips_applied_out), 64'd3072);
    @(negedge clk_in);
    chk_mem("ones_mem", 7, '0, v, NC);
    chk("ones_flips_hold", 64'(flips_applied_out), 64'd3072);
    load_mem(3);
    v = '0;
    v[63] = 1'b1;
    v[64] = 1'b1;
    base = nwr;
    run(v);
    chk("bound_cycles", 64'(cyc), 64'd53);
    chk("bound_writes", 64'(nwr - base), 64'd2);
    chk("bound_flips", 64'(flips_applied_out), 64'd2);
    @(negedge clk_in);
    chk_mem("bound_mem", 3, '0, v, NC);
    chk("bound_word0", mem[0], pat(3, 0) ^ 64'h8000_0000_0000_0000);
    chk("bound_word1", mem[1], pat(3, 1) ^ 64'h1);
    load_mem(5);
    ve = '0;
    ve[200] = 1'b1;
    ve[700] = 1'b1;
    ve[701] = 1'b1;
    base = nwr;
    @(negedge clk_in);
    flip_weight_in = ve;
    flip_valid_in = 1'b1;
    @(negedge clk_in);
    flip_valid_in = 1'b0;
    cyc = 1;
    while (done_out !== 1'b1 && cyc < 400) begin
      if (cyc == 4) begin
        flip_weight_in = '1;
        flip_valid_in = 1'b1;
      end
      @(negedge clk_in);
      flip_valid_in = 1'b0;
      cyc++;
    end
    chk("busy_cycles", 64'(cyc), 64'd53);
    chk("busy_writes", 64'(nwr - base), 64'd2);
    chk("busy_flips", 64'(flips_applied_out), 64'd3);
    chk_mem("busy_mem", 5, '0, ve, NC);
    base = nwr;
    @(negedge clk_in);
    chk("rst_idle_ready", 64'(ready_out), 64'd1);
    flip_weight_in = '1;
    flip_valid_in = 1'b1;
    @(negedge clk_in);
    flip_valid_in = 1'b0;
    cyc = 1;
    chk("rst_accepted", 64'(ready_out), 64'd0);
    while (cyc < 17) begin
      @(negedge clk_in);
      cyc++;
    end
    chk("rst_wait_addr", 64'(bram_addr_out), 64'd5);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_we", 64'(bram_we_out), 64'd0);
    chk("mid_rst_ready", 64'(ready_out), 64'd1);
    chk("mid_rst_flips", 64'(flips_applied_out), 64'd0);
    chk("mid_rst_done", 64'(done_out), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("post_rst_ready", 64'(ready_out), 64'd1);
    chk("post_rst_writes", 64'(nwr - base), 64'd5);
    chk_mem("post_rst_mem", 5, ve, '1, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
